// File: rtl/multicycle_mips_core.sv
// multicycle_mips_core
//   Multicycle MIPS-subset CPU: control FSM, 3-bit-op ALU, 32x32 register
//   file, instruction ROM and data RAM in one module. The data-memory write
//   port is exported so the surrounding system can observe stores.
//
// Parameters
//   MEM_WORDS  words in imem and in dmem (power of 2); addresses wrap
//   IMEM_FILE  name of the imem hex image; imem contents come from IMEM_INIT
//   IMEM_INIT  imem contents
//
// Ports
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-high
//   writedata  out 32   store data (register B)
//   dataadr    out 32   data address (ALUOut register)
//   memwrite   out  1   high for the whole MEMWR cycle of an sw
//
// Build option
//   MIPS_BNE_EN  when defined, opcode 0x05 (bne) branches if A != B;
//                otherwise 0x05 is treated as an unknown opcode.

module multicycle_mips_core #(
   parameter int unsigned                  MEM_WORDS = 64,
   parameter string                        IMEM_FILE = "memfile.dat",
   parameter logic [MEM_WORDS-1:0][31:0]   IMEM_INIT = '0
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] writedata,
   output logic [31:0] dataadr,
   output logic        memwrite
);

   localparam int unsigned AW = $clog2(MEM_WORDS);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
`ifdef MIPS_BNE_EN
   localparam logic [5:0] OP_BNE   = 6'h05;
`endif

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
      S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP
   } state_t;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_op_t;

   // imem is a ROM built once at time 0 from IMEM_INIT.
   function automatic logic [MEM_WORDS-1:0][31:0] imem_image();
      logic [MEM_WORDS-1:0][31:0] img;
      for (int unsigned i = 0; i < MEM_WORDS; i++) img[i[AW-1:0]] = IMEM_INIT[i[AW-1:0]];
      return img;
   endfunction

   function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] x,
                                       input logic [31:0] y);
      logic [31:0] r;
      r = x + y;
      case (op)
         ALU_AND: r = x & y;
         ALU_OR:  r = x | y;
         ALU_SUB: r = x - y;
         ALU_SLT: r = {31'b0, $signed(x) < $signed(y)};
         default: r = x + y;
      endcase
      return r;
   endfunction

   logic [MEM_WORDS-1:0][31:0] imem = imem_image();
   logic [31:0]                dmem [MEM_WORDS];

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] aluout_q, aluout_d;
   logic [31:0] mdr_q, mdr_d;
   logic [31:0] rf_q [32];
   logic [31:0] rf_d [32];

   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        dmem_we;

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] imm_sext;
   alu_op_t     alu_op;
   logic        funct_ok;
   logic        branch_ne;

   assign opcode   = ir_q[31:26];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign funct    = ir_q[5:0];
   assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

`ifdef MIPS_BNE_EN
   assign branch_ne = (opcode == OP_BNE);
`else
   assign branch_ne = 1'b0;
`endif

   always_comb begin
      alu_op   = ALU_ADD;
      funct_ok = 1'b1;
      case (funct)
         6'h20:   alu_op = ALU_ADD;
         6'h22:   alu_op = ALU_SUB;
         6'h24:   alu_op = ALU_AND;
         6'h25:   alu_op = ALU_OR;
         6'h2A:   alu_op = ALU_SLT;
         default: funct_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      aluout_d = aluout_q;
      mdr_d    = mdr_q;
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      dmem_we  = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_d    = imem[pc_q[AW+1:2]];
            pc_d    = pc_q + 32'd4;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            a_d      = rf_q[rs];
            b_d      = rf_q[rt];
            aluout_d = pc_q + {imm_sext[29:0], 2'b00};
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_BNE_EN
               OP_BNE:       state_d = S_BRANCH;
`endif
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            aluout_d = a_q + imm_sext;
            state_d  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mdr_d   = dmem[aluout_q[AW+1:2]];
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            rf_we    = 1'b1;
            rf_waddr = rt;
            rf_wdata = mdr_q;
            state_d  = S_FETCH;
         end
         S_MEMWR: begin
            dmem_we = 1'b1;
            state_d = S_FETCH;
         end
         S_EXEC: begin
            // Unknown funct ends the instruction here and leaves ALUOut alone.
            if (funct_ok) begin
               aluout_d = alu(alu_op, a_q, b_q);
               state_d  = S_ALUWB;
            end else begin
               state_d  = S_FETCH;
            end
         end
         S_ALUWB: begin
            rf_we    = 1'b1;
            rf_waddr = rd;
            rf_wdata = aluout_q;
            state_d  = S_FETCH;
         end
         S_ADDIEX: begin
            aluout_d = a_q + imm_sext;
            state_d  = S_ADDIWB;
         end
         S_ADDIWB: begin
            rf_we    = 1'b1;
            rf_waddr = rt;
            rf_wdata = aluout_q;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            // ALUOut holds the target computed in DECODE; bne inverts the test.
            if ((a_q == b_q) != branch_ne) pc_d = aluout_q;
            state_d = S_FETCH;
         end
         S_JUMP: begin
            pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      rf_d = rf_q;
      if (rf_we && (rf_waddr != 5'd0)) rf_d[rf_waddr] = rf_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_FETCH;
         pc_q     <= '0;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         aluout_q <= '0;
         mdr_q    <= '0;
         rf_q     <= '{default: '0};
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         aluout_q <= aluout_d;
         mdr_q    <= mdr_d;
         rf_q     <= rf_d;
      end
   end

   // dmem is not cleared by reset; dmem_we is low while reset is held.
   always_ff @(posedge clk) begin
      if (dmem_we) dmem[aluout_q[AW+1:2]] <= b_q;
   end

   assign memwrite  = dmem_we;
   assign dataadr   = aluout_q;
   assign writedata = b_q;

endmodule

// File: tb/tb_multicycle_mips_core.sv
module tb_multicycle_mips_core;

   localparam int unsigned MEM_WORDS = 64;
   localparam int unsigned AW        = 6;

   function automatic logic [MEM_WORDS-1:0][31:0] prog_image();
      logic [MEM_WORDS-1:0][31:0] p;
      p = '0;
`ifdef MIPS_BNE_EN
      p[0]  = 32'h20020001;
      p[1]  = 32'h14400001;
      p[2]  = 32'hac000000;
      p[3]  = 32'hac020004;
`else
      p[0]  = 32'h20020005;
      p[1]  = 32'h2003000c;
      p[2]  = 32'h2067fff7;
      p[3]  = 32'h00e22025;
      p[4]  = 32'h00642824;
      p[5]  = 32'h00a42820;
      p[6]  = 32'h10a7000a;
      p[7]  = 32'h0064202a;
      p[8]  = 32'h10800001;
      p[9]  = 32'h20050000;
      p[10] = 32'h00e2202a;
      p[11] = 32'h00853820;
      p[12] = 32'h00e23822;
      p[13] = 32'hac670044;
      p[14] = 32'h8c020050;
      p[15] = 32'h08000011;
      p[16] = 32'h20020001;
      p[17] = 32'hac020054;
`endif
      return p;
   endfunction

   localparam logic [MEM_WORDS-1:0][31:0] PROG = prog_image();

   typedef struct packed {
      logic [31:0] cyc;
      logic [31:0] adr;
      logic [31:0] dat;
   } st_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] writedata;
   logic [31:0] dataadr;
   logic        memwrite;

   st_t         exp_q[$];
   logic [31:0] m_dmem [MEM_WORDS];
   int          checks   = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   multicycle_mips_core #(
      .MEM_WORDS (MEM_WORDS),
      .IMEM_FILE (""),
      .IMEM_INIT (PROG)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .writedata (writedata),
      .dataadr   (dataadr),
      .memwrite  (memwrite)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Instruction-level interpreter. Instruction n starts in cycle c (cycle 1
   // is the first FETCH after reset release) and lasts its ISA latency; its
   // effects count only if it completes by cycle 'limit'. A store is visible
   // in its 4th cycle. st_next reports a store visible in cycle limit+1.
   task automatic model_run(input int unsigned limit, input bit commit,
                            output int unsigned first_st, output bit st_next);
      logic [31:0] r [32];
      logic [31:0] mem [MEM_WORDS];
      logic [31:0] pc, ins, a, b, simm, pc4, npc, ea, res;
      logic [5:0]  op, fn;
      logic [4:0]  wreg;
      bit          wen, is_st;
      int unsigned c, lat;
      for (int i = 0; i < 32; i++) r[i] = '0;
      mem      = m_dmem;
      pc       = '0;
      c        = 1;
      first_st = 0;
      st_next  = 1'b0;
      while (1'b1) begin
         ins   = PROG[pc[AW+1:2]];
         op    = ins[31:26];
         fn    = ins[5:0];
         a     = r[ins[25:21]];
         b     = r[ins[20:16]];
         simm  = {{16{ins[15]}}, ins[15:0]};
         ea    = a + simm;
         pc4   = pc + 32'd4;
         npc   = pc4;
         wen   = 1'b0;
         wreg  = '0;
         res   = '0;
         is_st = 1'b0;
         lat   = 2;
         case (op)
            6'h00: begin
               lat  = 4;
               wen  = 1'b1;
               wreg = ins[15:11];
               case (fn)
                  6'h20:   res = a + b;
                  6'h22:   res = a - b;
                  6'h24:   res = a & b;
                  6'h25:   res = a | b;
                  6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                  default: begin lat = 3; wen = 1'b0; end
               endcase
            end
            6'h08: begin lat = 4; wen = 1'b1; wreg = ins[20:16]; res = ea; end
            6'h23: begin lat = 5; wen = 1'b1; wreg = ins[20:16]; res = mem[ea[AW+1:2]]; end
            6'h2B: begin lat = 4; is_st = 1'b1; end
            6'h04: begin lat = 3; if (a == b) npc = pc4 + (simm << 2); end
`ifdef MIPS_BNE_EN
            6'h05: begin lat = 3; if (a != b) npc = pc4 + (simm << 2); end
`endif
            6'h02: begin lat = 3; npc = {pc4[31:28], ins[25:0], 2'b00}; end
            default: lat = 2;
         endcase
         if (is_st && (c + 3 == limit + 1)) st_next = 1'b1;
         if (c + lat - 1 > limit) break;
         if (is_st) begin
            mem[ea[AW+1:2]] = b;
            if (first_st == 0) first_st = c + 3;
            if (commit) exp_q.push_back({c + 32'd3, ea, b});
         end
         if (wen && (wreg != 5'd0)) r[wreg] = res;
         pc = npc;
         c  = c + lat;
      end
      if (commit) m_dmem = mem;
   endtask

   // Called with reset high just after a rising edge; releases reset, runs
   // 'len' cycles, then asserts reset asynchronously inside cycle len+1.
   task automatic episode(input int unsigned len);
      int unsigned f;
      bit          nxt;
      exp_q.delete();
      model_run(len, 1'b1, f, nxt);
      @(posedge clk);
      #1 reset = 1'b0;
      chk("release_memwrite", {31'b0, memwrite}, 32'd0);
      chk("release_dataadr", dataadr, 32'd0);
      chk("release_writedata", writedata, 32'd0);
      repeat (len) @(posedge clk);
      #1;
      chk("memwrite_before_abort", {31'b0, memwrite}, {31'b0, nxt});
      reset = 1'b1;
      #1;
      chk("abort_memwrite", {31'b0, memwrite}, 32'd0);
      chk("abort_dataadr", dataadr, 32'd0);
      chk("stores_drained", 32'(exp_q.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      int unsigned cyc;
      st_t         e;
      cyc = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            cyc = 0;
         end else begin
            cyc++;
            while ((exp_q.size() > 0) && (exp_q[0].cyc < cyc)) begin
               e = exp_q.pop_front();
               checks++;
               failures++;
               $display("FAIL store_missing: no memwrite in cycle %0d, expected adr=%0d data=%0d",
                        e.cyc, e.adr, e.dat);
            end
            if (memwrite) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL store_unexpected: cycle %0d adr=%0d data=%0d, expected no store",
                           cyc, dataadr, writedata);
               end else begin
                  e = exp_q.pop_front();
                  if ((e.cyc != cyc) || (dataadr !== e.adr) || (writedata !== e.dat)) begin
                     failures++;
                     $display("FAIL store: got cycle %0d adr=%0d data=%0d, expected cycle %0d adr=%0d data=%0d",
                              cyc, dataadr, writedata, e.cyc, e.adr, e.dat);
                  end
               end
            end
         end
      end
   end

   initial begin : stim
      int unsigned f;
      bit          unused_nxt;
      reset = 1'b1;
      for (int i = 0; i < int'(MEM_WORDS); i++) m_dmem[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_memwrite", {31'b0, memwrite}, 32'd0);
      chk("reset_dataadr", dataadr, 32'd0);
      chk("reset_writedata", writedata, 32'd0);

      model_run(1000, 1'b0, f, unused_nxt);
      episode(f - 1);        // reset lands in the MEMWR cycle of the first store
      episode(400);          // full program, zero fill and address wrap
      for (int n = 0; n < 6; n++) episode($urandom_range(320, 3));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
